// File: rtl/arf_seq_ctrl.sv
// Micro-sequencer for the 8-bit address register file (PC, AR, SP, PCPast).
// Runs fetch, jump, push/pop and call/return, with stack bound checks and a memory port.
module arf_seq_ctrl #(
  parameter logic [7:0] SP_FULL  = 8'h00,
  parameter logic [7:0] SP_EMPTY = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_operand,
  output logic       done,
  output logic       err,
  output logic [7:0] result,
  output logic [1:0] arf_funsel,
  output logic [3:0] arf_rsel,
  output logic [1:0] arf_outasel,
  output logic [1:0] arf_outbsel,
  output logic [7:0] arf_i,
  input  logic [7:0] arf_outa,
  input  logic [7:0] arf_outb,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack
);

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_CHK, S_PRE, S_SEL2, S_MEM, S_LDPP, S_POST, S_LOAD, S_DONE
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_FETCH = 3'b001;
  localparam logic [2:0] OP_JUMP  = 3'b010;
  localparam logic [2:0] OP_PUSH  = 3'b011;
  localparam logic [2:0] OP_POP   = 3'b100;
  localparam logic [2:0] OP_CALL  = 3'b101;
  localparam logic [2:0] OP_RET   = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  localparam logic [1:0] SEL_AR = 2'b00;
  localparam logic [1:0] SEL_SP = 2'b01;
  localparam logic [1:0] SEL_PC = 2'b11;

  localparam logic [1:0] FUN_CLR  = 2'b00;
  localparam logic [1:0] FUN_LOAD = 2'b01;
  localparam logic [1:0] FUN_INC  = 2'b10;
  localparam logic [1:0] FUN_DEC  = 2'b11;

  localparam logic [3:0] RS_NONE = 4'b0000;
  localparam logic [3:0] RS_PC   = 4'b1000;
  localparam logic [3:0] RS_SP   = 4'b0010;
  localparam logic [3:0] RS_PP   = 4'b0001;

  // OutA/OutB select pair {A,B} used for the whole life of a command
  function automatic logic [3:0] sel_pair(input logic [2:0] op);
    logic [3:0] pair;
    case (op)
      OP_PUSH, OP_POP, OP_RET: pair = {SEL_SP, SEL_SP};
      OP_CALL:                 pair = {SEL_SP, SEL_PC};
      default:                 pair = {SEL_PC, SEL_PC};
    endcase
    return pair;
  endfunction

  state_t     state_r, state_s;
  logic [2:0] op_r;
  logic [7:0] operand_r;
  logic [7:0] result_r;
  logic       err_r;
  logic [1:0] outasel_r;
  logic [1:0] outbsel_r;
  logic       accept_s;
  logic       chk_fail_s;
  logic       push_like_s;

  assign accept_s    = (state_r == S_IDLE) && cmd_valid;
  assign push_like_s = (op_r == OP_PUSH) || (op_r == OP_CALL);

  // State, latched command and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      op_r      <= OP_NOP;
      operand_r <= 8'h00;
      result_r  <= 8'h00;
      err_r     <= 1'b0;
      outasel_r <= SEL_AR;
      outbsel_r <= SEL_AR;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r                   <= cmd_op;
        operand_r              <= cmd_operand;
        {outasel_r, outbsel_r} <= sel_pair(cmd_op);
        err_r                  <= (cmd_op == OP_ILL);
      end else if (state_r == S_DONE) begin
        outasel_r <= SEL_AR;
        outbsel_r <= SEL_AR;
      end
      if (chk_fail_s) begin
        err_r <= 1'b1;
      end
      if ((state_r == S_MEM) && mem_ack && !push_like_s) begin
        result_r <= mem_rdata;
      end
    end
  end

  // Next-state sequencing for every command
  always_comb begin
    state_s    = state_r;
    chk_fail_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP, OP_ILL: state_s = S_DONE;
            OP_JUMP:        state_s = S_LOAD;
            default:        state_s = S_SEL;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SEL: begin
        if (op_r == OP_FETCH) begin
          state_s = S_MEM;
        end else begin
          state_s = S_CHK;
        end
      end
      S_CHK: begin
        // A refused stack operation skips memory and the ARF entirely
        if (push_like_s) begin
          if (arf_outa == SP_FULL) begin
            state_s    = S_DONE;
            chk_fail_s = 1'b1;
          end else begin
            state_s = S_MEM;
          end
        end else begin
          if (arf_outa == SP_EMPTY) begin
            state_s    = S_DONE;
            chk_fail_s = 1'b1;
          end else begin
            state_s = S_PRE;
          end
        end
      end
      S_PRE:  state_s = S_SEL2;
      S_SEL2: state_s = S_MEM;
      S_MEM: begin
        if (mem_ack) begin
          case (op_r)
            OP_FETCH:         state_s = S_LDPP;
            OP_PUSH, OP_CALL: state_s = S_POST;
            OP_RET:           state_s = S_LOAD;
            default:          state_s = S_DONE;
          endcase
        end else begin
          state_s = S_MEM;
        end
      end
      S_LDPP: state_s = S_POST;
      S_POST: begin
        if (op_r == OP_CALL) begin
          state_s = S_LOAD;
        end else begin
          state_s = S_DONE;
        end
      end
      S_LOAD:  state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode from registered state and op
  always_comb begin
    cmd_ready  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    arf_rsel   = RS_NONE;
    arf_funsel = FUN_CLR;
    arf_i      = operand_r;
    case (state_r)
      S_IDLE: cmd_ready = 1'b1;
      S_PRE: begin
        arf_rsel   = RS_SP;
        arf_funsel = FUN_INC;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = push_like_s;
      end
      S_LDPP: begin
        arf_rsel   = RS_PP;
        arf_funsel = FUN_LOAD;
        arf_i      = arf_outb;
      end
      S_POST: begin
        if (op_r == OP_FETCH) begin
          arf_rsel   = RS_PC;
          arf_funsel = FUN_INC;
        end else begin
          arf_rsel   = RS_SP;
          arf_funsel = FUN_DEC;
        end
      end
      S_LOAD: begin
        arf_rsel   = RS_PC;
        arf_funsel = FUN_LOAD;
        if (op_r == OP_RET) begin
          arf_i = result_r;
        end else begin
          arf_i = operand_r;
        end
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_r;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  assign result      = result_r;
  assign arf_outasel = outasel_r;
  assign arf_outbsel = outbsel_r;
  assign mem_addr    = arf_outa;
  assign mem_wdata   = (op_r == OP_CALL) ? arf_outb : operand_r;

endmodule

// File: tb/tb_arf_seq_ctrl.sv
// Scoreboard bench for arf_seq_ctrl with a behavioural ARF and a wait-state memory.
module tb_arf_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_operand;
  logic       done;
  logic       err;
  logic [7:0] result;
  logic [1:0] arf_funsel;
  logic [3:0] arf_rsel;
  logic [1:0] arf_outasel;
  logic [1:0] arf_outbsel;
  logic [7:0] arf_i;
  logic [7:0] arf_outa;
  logic [7:0] arf_outb;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  arf_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .done(done), .err(err), .result(result),
    .arf_funsel(arf_funsel), .arf_rsel(arf_rsel), .arf_outasel(arf_outasel),
    .arf_outbsel(arf_outbsel), .arf_i(arf_i), .arf_outa(arf_outa), .arf_outb(arf_outb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic       err;
    logic [7:0] res;
    int         lat;
    int         nreq;
    logic [7:0] addr;
    logic       we;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   acc_gap = 0;
  int   req_cnt = 0;
  logic [7:0] req_addr = 8'h00;
  logic       req_we = 1'b0;

  // ARF and memory model state
  logic [7:0] pc_m = 8'h00, ar_m = 8'h00, sp_m = 8'h00, pp_m = 8'h00;
  logic [7:0] outa_m = 8'h00, outb_m = 8'h00;
  logic [7:0] mem_m [256];
  logic       ld_pc_en = 1'b0, ld_sp_en = 1'b0, ld_mem_en = 1'b0;
  logic [7:0] ld_pc = 8'h00, ld_sp = 8'h00, ld_mem_addr = 8'h00, ld_mem_data = 8'h00;
  int         wait_n = 0;
  int         wcnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic e, input logic [7:0] r, input int lat, input int nreq,
                              input logic [7:0] addr, input logic we);
    exp_t x;
    x.err = e; x.res = r; x.lat = lat; x.nreq = nreq; x.addr = addr; x.we = we;
    return x;
  endfunction

  function automatic logic [7:0] arf_next(input logic [7:0] v, input logic [1:0] fs, input logic [7:0] d);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return d;
      2'b10:   return v + 8'h01;
      default: return v - 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] arf_rd(input logic [1:0] s);
    case (s)
      2'b00:   return ar_m;
      2'b01:   return sp_m;
      2'b10:   return pp_m;
      default: return pc_m;
    endcase
  endfunction

  assign arf_outa  = outa_m;
  assign arf_outb  = outb_m;
  assign mem_ack   = mem_req && (wcnt == wait_n);
  assign mem_rdata = mem_m[mem_addr];

  // Registered ARF outputs, register writes and memory writes
  always @(posedge clk) begin
    outa_m <= arf_rd(arf_outasel);
    outb_m <= arf_rd(arf_outbsel);
    if (ld_pc_en) pc_m <= ld_pc;
    else if (arf_rsel[3]) pc_m <= arf_next(pc_m, arf_funsel, arf_i);
    if (arf_rsel[2]) ar_m <= arf_next(ar_m, arf_funsel, arf_i);
    if (ld_sp_en) sp_m <= ld_sp;
    else if (arf_rsel[1]) sp_m <= arf_next(sp_m, arf_funsel, arf_i);
    if (arf_rsel[0]) pp_m <= arf_next(pp_m, arf_funsel, arf_i);
    if (ld_mem_en) mem_m[ld_mem_addr] <= ld_mem_data;
    else if (mem_req && mem_ack && mem_we) mem_m[mem_addr] <= mem_wdata;
  end

  // Wait-state counter for the memory responder
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: track accepts and memory cycles, score each done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        if (req_cnt == 0) begin
          req_addr = mem_addr;
          req_we   = mem_we;
        end
        req_cnt++;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("err", 32'(err), 32'(mon_e.err));
          check_val("result", 32'(result), 32'(mon_e.res));
          check_val("latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
          check_val("mem_req_cycles", 32'(req_cnt), 32'(mon_e.nreq));
          if (mon_e.nreq > 0) begin
            check_val("mem_addr", 32'(req_addr), 32'(mon_e.addr));
            check_val("mem_we", 32'(req_we), 32'(mon_e.we));
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        acc_gap = cyc - acc_cyc;
        acc_cyc = cyc;
        req_cnt = 0;
      end
    end
  end

  task automatic preload(input logic pe, input logic [7:0] pv, input logic se, input logic [7:0] sv);
    ld_pc_en = pe; ld_pc = pv; ld_sp_en = se; ld_sp = sv;
    @(posedge clk); #1;
    ld_pc_en = 1'b0; ld_sp_en = 1'b0;
  endtask

  task automatic preload_mem(input logic [7:0] a, input logic [7:0] d);
    ld_mem_en = 1'b1; ld_mem_addr = a; ld_mem_data = d;
    @(posedge clk); #1;
    ld_mem_en = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] opnd, input exp_t e);
    int n;
    n = 0;
    cmd_op = op; cmd_operand = opnd; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check_val("accept_timeout", 32'(cmd_ready), 32'd1);
    sb_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check_val("done_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] opnd, input exp_t e);
    send(op, opnd, e);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_operand = 8'h00;
    #12;
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_result", 32'(result), 32'h00);
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_rsel", 32'(arf_rsel), 32'h0);
    check_val("rst_funsel", 32'(arf_funsel), 32'h0);
    check_val("rst_outasel", 32'(arf_outasel), 32'h0);
    check_val("rst_outbsel", 32'(arf_outbsel), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // FETCH with two wait states
    preload(1'b1, 8'h10, 1'b0, 8'h00);
    preload_mem(8'h10, 8'hA5);
    wait_n = 2;
    issue(3'b001, 8'h00, mk(1'b0, 8'hA5, 7, 3, 8'h10, 1'b0));
    check_val("fetch_pc", 32'(pc_m), 32'h11);
    check_val("fetch_pcpast", 32'(pp_m), 32'h10);

    // PUSH then POP
    preload(1'b0, 8'h00, 1'b1, 8'h80);
    wait_n = 0;
    issue(3'b011, 8'h3C, mk(1'b0, 8'hA5, 5, 1, 8'h80, 1'b1));
    check_val("push_mem", 32'(mem_m[8'h80]), 32'h3C);
    check_val("push_sp", 32'(sp_m), 32'h7F);
    wait_n = 1;
    issue(3'b100, 8'h00, mk(1'b0, 8'h3C, 7, 2, 8'h80, 1'b0));
    check_val("pop_sp", 32'(sp_m), 32'h80);

    // Stack full / empty rejection
    wait_n = 0;
    preload(1'b0, 8'h00, 1'b1, 8'h00);
    issue(3'b011, 8'h55, mk(1'b1, 8'h3C, 3, 0, 8'h00, 1'b0));
    check_val("full_sp", 32'(sp_m), 32'h00);
    preload(1'b0, 8'h00, 1'b1, 8'hFF);
    issue(3'b100, 8'h00, mk(1'b1, 8'h3C, 3, 0, 8'h00, 1'b0));
    check_val("empty_sp", 32'(sp_m), 32'hFF);

    // CALL then RET
    preload(1'b1, 8'h22, 1'b1, 8'h90);
    issue(3'b101, 8'h40, mk(1'b0, 8'h3C, 6, 1, 8'h90, 1'b1));
    check_val("call_mem", 32'(mem_m[8'h90]), 32'h22);
    check_val("call_pc", 32'(pc_m), 32'h40);
    check_val("call_sp", 32'(sp_m), 32'h8F);
    issue(3'b110, 8'h00, mk(1'b0, 8'h22, 7, 1, 8'h90, 1'b0));
    check_val("ret_pc", 32'(pc_m), 32'h22);
    check_val("ret_sp", 32'(sp_m), 32'h90);

    // Reset asserted while FETCH waits on memory
    preload(1'b1, 8'h10, 1'b0, 8'h00);
    wait_n = 20;
    send(3'b001, 8'h00, mk(1'b0, 8'h00, 0, 0, 8'h00, 1'b0));
    for (int i = 0; i < 20; i++) begin
      if (mem_req) break;
      @(posedge clk); #1;
    end
    check_val("rst_test_in_mem", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_val("midrst_mem_req", 32'(mem_req), 32'd0);
    check_val("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("midrst_done", 32'(done), 32'd0);
    sb_q.delete();
    @(negedge clk); rst_n = 1'b1;
    wait_n = 0;
    @(posedge clk); #1;
    check_val("midrst_pc", 32'(pc_m), 32'h10);
    issue(3'b010, 8'h05, mk(1'b0, 8'h00, 2, 0, 8'h00, 1'b0));
    check_val("jump_pc", 32'(pc_m), 32'h05);

    // Illegal op then NOP with cmd_valid held throughout
    sb_q.push_back(mk(1'b1, 8'h00, 1, 0, 8'h00, 1'b0));
    sb_q.push_back(mk(1'b0, 8'h00, 1, 0, 8'h00, 1'b0));
    cmd_op = 3'b111; cmd_operand = 8'h00; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 3'b000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done();
    check_val("accept_gap", 32'(acc_gap), 32'd2);
    check_val("nop_pc", 32'(pc_m), 32'h05);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
